// File: rtl/reg_slice_hs_pkg.sv
// Shared types and helpers for the reg_slice_hs register slice.
//   slice_mode_t : SLICE_FWD  - valid/data registered, ready combinational
//                  SLICE_FULL - valid/data/ready registered via skid buffer
//   occ_width()  : width of the occupancy counter for a given stage count
package reg_slice_pkg;

  typedef enum logic {
    SLICE_FWD,
    SLICE_FULL
  } slice_mode_t;

  function automatic int occ_width(input int num_stages);
    return $clog2(2 * num_stages + 1);
  endfunction

endpackage

// File: rtl/reg_slice_hs_if.sv
// Valid/ready stream interface carrying a C_WIDTH payload.
//   valid : beat valid (producer)
//   ready : consumer can accept (consumer)
//   data  : payload (producer)
// master = producer side, slave = consumer side.
interface reg_slice_hs_if #(
  parameter int C_WIDTH = 32
);
  logic               valid;
  logic               ready;
  logic [C_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/reg_slice_hs_stage.sv
// One register slice stage.
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous clear of the stored beat(s)
//   in_*         : upstream handshake
//   out_*        : downstream handshake
//   count        : number of beats held (0..2)
// SLICE_FWD holds one beat and passes ready through combinationally.
// SLICE_FULL holds up to two beats (main + skid); in_ready is a flop output.
module reg_slice_hs_stage
  import reg_slice_pkg::*;
#(
  parameter int          C_WIDTH = 32,
  parameter slice_mode_t C_MODE  = SLICE_FULL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH-1:0] out_data,
  output logic [1:0]         count
);

  logic               main_valid;
  logic [C_WIDTH-1:0] main_data;

  assign out_valid = main_valid;
  assign out_data  = main_data;

  if (C_MODE == SLICE_FULL) begin : g_full
    logic               skid_valid;
    logic [C_WIDTH-1:0] skid_data;

    assign in_ready = !skid_valid;
    assign count    = {1'b0, main_valid} + {1'b0, skid_valid};

    // skid_valid implies main_valid, so an empty main never has to look at the skid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_valid <= 1'b0;
        main_data  <= '0;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || out_ready) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= in_valid;
          if (in_valid) main_data <= in_data;
        end
      end else if (in_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end else begin : g_fwd
    assign in_ready = !main_valid || out_ready;
    assign count    = {1'b0, main_valid};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
      end else if (in_ready) begin
        main_valid <= in_valid;
        if (in_valid) main_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/reg_slice_hs.sv
// Multi-stage valid/ready register slice.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear of all stored beats
//   s          : upstream stream (slave modport)
//   m          : downstream stream (master modport)
//   occupancy  : number of beats currently held
// Stages are chained s -> stage 0 -> ... -> stage N-1 -> m.
module reg_slice_hs
  import reg_slice_pkg::*;
#(
  parameter int          C_WIDTH      = 32,
  parameter int          C_NUM_STAGES = 2,
  parameter slice_mode_t C_MODE       = SLICE_FULL
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  reg_slice_hs_if.slave                       s,
  reg_slice_hs_if.master                      m,
  output logic [occ_width(C_NUM_STAGES)-1:0]  occupancy
);

  localparam int OW = occ_width(C_NUM_STAGES);

  logic                    init_q;
  logic [C_NUM_STAGES:0]   chain_valid;
  logic [C_NUM_STAGES:0]   chain_ready;
  logic [C_WIDTH-1:0]      chain_data [C_NUM_STAGES+1];
  logic [1:0]              stage_cnt  [C_NUM_STAGES];

  // keeps s.ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  // flush blocks acceptance so the flushed cycle never admits a beat
  assign chain_valid[0] = s.valid && init_q && !flush;
  assign chain_data[0]  = s.data;
  assign s.ready        = chain_ready[0] && init_q && !flush;

  for (genvar i = 0; i < C_NUM_STAGES; i++) begin : g_stage
    reg_slice_hs_stage #(
      .C_WIDTH (C_WIDTH),
      .C_MODE  (C_MODE)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (chain_valid[i]),
      .in_ready  (chain_ready[i]),
      .in_data   (chain_data[i]),
      .out_valid (chain_valid[i+1]),
      .out_ready (chain_ready[i+1]),
      .out_data  (chain_data[i+1]),
      .count     (stage_cnt[i])
    );
  end

  assign m.valid                   = chain_valid[C_NUM_STAGES];
  assign m.data                    = chain_data[C_NUM_STAGES];
  assign chain_ready[C_NUM_STAGES] = m.ready;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < C_NUM_STAGES; i++) begin
      occupancy = occupancy + OW'(stage_cnt[i]);
    end
  end

endmodule
